// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    FE_FETCH, // request outstanding at pc_q
    FE_HOLD,  // word received while decode stalled, parked in hold buffer
    FE_DRAIN  // redirect arrived mid-request; waiting to discard the stale word
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction addresses are word aligned; low bits of any target are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_fetch_if.sv
// Instruction-memory request bus: single outstanding request, req/ready handshake.
// Latency: variable, the memory completes a request by raising imem_ready.
// Backpressure: imem_req and imem_addr hold steady until imem_ready is seen.
// Signals: imem_req/imem_addr driven by fetch, imem_rdata/imem_ready driven by memory.
interface stage_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/stage_fetch_if_de_reg.sv
// IF/DE pipeline register with priority rst > clear > stall > load.
// Latency: 1 cycle from ld_* to de_*.
// Backpressure: stall holds contents; clear overrides stall and inserts a bubble.
// Ports: clk, rst, clear, stall, ld_{instr,pc,pc_plus4,valid} in; de_{instr,pc,pc_plus4,valid} out.
module if_de_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        stall,
  input  logic [31:0] ld_instr,
  input  logic [31:0] ld_pc,
  input  logic [31:0] ld_pc_plus4,
  input  logic        ld_valid,
  output logic [31:0] de_instr,
  output logic [31:0] de_pc,
  output logic [31:0] de_pc_plus4,
  output logic        de_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_instr    <= NOP_INSTR;
      de_pc       <= '0;
      de_pc_plus4 <= '0;
      de_valid    <= 1'b0;
    end else if (clear) begin
      de_instr    <= NOP_INSTR;
      de_pc       <= '0;
      de_pc_plus4 <= '0;
      de_valid    <= 1'b0;
    end else if (!stall) begin
      de_instr    <= ld_instr;
      de_pc       <= ld_pc;
      de_pc_plus4 <= ld_pc_plus4;
      de_valid    <= ld_valid;
    end
  end

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch: owns PC, issues one outstanding imem request, feeds IF/DE.
// Latency: word returned with imem_ready appears on de_* at the next posedge.
// Backpressure: de_stall parks a returned word in a hold buffer and drops imem_req.
// Ports: clk, rst, de_stall, de_clear, ex_pc_src, ex_pc_target, imem (master), de_* outputs.
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched / perf_wait counters.
module stage_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de_stall,
  input  logic               de_clear,
  input  logic               ex_pc_src,
  input  logic [31:0]        ex_pc_target,
  stage_fetch_if.master      imem,
  output logic [31:0]        de_instr,
  output logic [31:0]        de_pc,
  output logic [31:0]        de_pc_plus4,
  output logic               de_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_wait
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  redir_q, redir_d;

  logic [31:0]  target;
  logic [31:0]  pc_inc;
  logic         squash;
  logic [31:0]  ld_instr, ld_pc, ld_pc_plus4;
  logic         ld_valid;

  assign target = word_align(ex_pc_target);
  assign pc_inc = pc_q + PC_STEP;

  // The request is live in FETCH and DRAIN; in DRAIN pc_q still holds the
  // stale address because the redirect target waits in redir_q.
  assign imem.imem_req  = !rst && (state_q != FE_HOLD);
  assign imem.imem_addr = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FE_FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      redir_q <= redir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    redir_d     = redir_q;
    squash      = 1'b0;
    // Default load is a bubble; it only lands when decode is not stalled.
    ld_instr    = NOP_INSTR;
    ld_pc       = '0;
    ld_pc_plus4 = '0;
    ld_valid    = 1'b0;

    case (state_q)
      FE_FETCH: begin
        if (ex_pc_src) begin
          squash = 1'b1;
          if (imem.imem_ready) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = FE_DRAIN;
          end
        end else if (imem.imem_ready) begin
          if (!de_stall) begin
            ld_instr    = imem.imem_rdata;
            ld_pc       = pc_q;
            ld_pc_plus4 = pc_inc;
            ld_valid    = 1'b1;
            pc_d        = pc_inc;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = FE_HOLD;
          end
        end
      end

      FE_HOLD: begin
        if (ex_pc_src) begin
          squash  = 1'b1;
          hold_d  = '0;
          pc_d    = target;
          state_d = FE_FETCH;
        end else begin
          ld_instr    = hold_q;
          ld_pc       = pc_q;
          ld_pc_plus4 = pc_inc;
          ld_valid    = 1'b1;
          if (!de_stall) begin
            pc_d    = pc_inc;
            state_d = FE_FETCH;
          end
        end
      end

      FE_DRAIN: begin
        // Whatever comes back belongs to the wrong path.
        squash = 1'b1;
        if (imem.imem_ready) begin
          pc_d    = ex_pc_src ? target : redir_q;
          state_d = FE_FETCH;
        end else if (ex_pc_src) begin
          redir_d = target;
        end
      end

      default: state_d = FE_FETCH;
    endcase
  end

  if_de_reg u_if_de_reg (
    .clk         (clk),
    .rst         (rst),
    .clear       (de_clear || squash),
    .stall       (de_stall),
    .ld_instr    (ld_instr),
    .ld_pc       (ld_pc),
    .ld_pc_plus4 (ld_pc_plus4),
    .ld_valid    (ld_valid),
    .de_instr    (de_instr),
    .de_pc       (de_pc),
    .de_pc_plus4 (de_pc_plus4),
    .de_valid    (de_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_wait    <= '0;
    end else begin
      if (ld_valid && !de_clear && !squash && !de_stall)
        perf_fetched <= perf_fetched + 32'd1;
      if (imem.imem_req && !imem.imem_ready)
        perf_wait <= perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Testbench for stage_fetch: directed scenarios plus randomized traffic against
// a transaction-level fetch model; every cycle's outputs are compared at negedge.
module tb_stage_fetch;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        stall_in = 1'b0, clear_in = 1'b0, src_in = 1'b0, ready_in = 1'b0;
  logic [31:0] tgt_in = '0;
  logic [31:0] de_instr, de_pc, de_pc_plus4;
  logic        de_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_wait;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Memory contents: a recognisable function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  stage_fetch_if imem ();
  assign imem.imem_ready = ready_in;
  assign imem.imem_rdata = ready_in ? mem_word(imem.imem_addr) : (32'hDEAD_BEEF ^ imem.imem_addr);

  stage_fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst_in),
    .de_stall     (stall_in),
    .de_clear     (clear_in),
    .ex_pc_src    (src_in),
    .ex_pc_target (tgt_in),
    .imem         (imem),
    .de_instr     (de_instr),
    .de_pc        (de_pc),
    .de_pc_plus4  (de_pc_plus4),
    .de_valid     (de_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_wait    (perf_wait)
`endif
  );

  // Model state: next address, whether a stalled word is parked, and whether
  // the outstanding request is already known to be wrong-path.
  logic [31:0] m_pc, m_word, m_target;
  bit          m_held, m_drain;
  logic [31:0] e_instr, e_pc, e_pc4;
  bit          e_valid;
  logic [31:0] m_fetched, m_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = TB_RESET_PC; m_word = '0; m_target = '0;
    m_held = 0; m_drain = 0;
    e_instr = '0; e_pc = '0; e_pc4 = '0; e_valid = 0;
    m_fetched = '0; m_wait = '0;
  endtask

  task automatic model_update();
    logic [31:0] t;
    logic [31:0] o_instr;
    bit squash, offer, bubble;
    t = {tgt_in[31:2], 2'b00};
    o_instr = '0; squash = 0; offer = 0; bubble = 0;
    if (rst_in) begin
      model_reset();
      return;
    end
    if (!m_held && !ready_in) m_wait++;
    if (src_in) begin
      squash = 1;
      if (m_held) begin
        m_held = 0; m_pc = t;
      end else if (m_drain) begin
        if (ready_in) begin m_pc = t; m_drain = 0; end
        else m_target = t;
      end else if (ready_in) begin
        m_pc = t;
      end else begin
        m_drain = 1; m_target = t;
      end
    end else if (m_drain) begin
      squash = 1;
      if (ready_in) begin m_pc = m_target; m_drain = 0; end
    end else if (m_held) begin
      if (!stall_in) begin offer = 1; o_instr = m_word; m_held = 0; end
    end else if (ready_in) begin
      if (!stall_in) begin offer = 1; o_instr = mem_word(m_pc); end
      else begin m_held = 1; m_word = mem_word(m_pc); end
    end else if (!stall_in) begin
      bubble = 1;
    end

    if (clear_in || squash || bubble) begin
      e_instr = '0; e_valid = 0; e_pc = '0; e_pc4 = '0;
    end else if (offer) begin
      e_instr = o_instr; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_valid = 1;
      m_fetched++;
    end
    if (offer) m_pc = m_pc + 32'd4;
  endtask

  // Called at a negedge: drive inputs, advance model at the posedge, return at the next negedge.
  task automatic step(input bit s, input bit c, input bit p, input logic [31:0] t, input bit r);
    stall_in = s; clear_in = c; src_in = p; tgt_in = t; ready_in = r;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", 32'(imem.imem_req), 32'(!rst_in && !m_held));
      if (!rst_in && !m_held) check("imem_addr", imem.imem_addr, m_pc);
      check("de_valid", 32'(de_valid), 32'(e_valid));
      check("de_instr", de_instr, e_instr);
      if (e_valid) begin
        check("de_pc", de_pc, e_pc);
        check("de_pc_plus4", de_pc_plus4, e_pc4);
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_wait", perf_wait, m_wait);
`endif
    end
  end

  initial begin
    model_reset();
    #1;
    check("rst_req", 32'(imem.imem_req), 32'h0);
    check("rst_valid", 32'(de_valid), 32'h0);
    check("rst_instr", de_instr, 32'h0);
    check("rst_pc", de_pc, 32'h0);
    check("rst_pc4", de_pc_plus4, 32'h0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_in = 1'b0;
    @(negedge clk);
    check("first_addr", imem.imem_addr, 32'h100);
    check("first_req", 32'(imem.imem_req), 32'h1);

    // Back-to-back fetch with memory always ready.
    step(0, 0, 0, 0, 1);
    check("seq_addr1", imem.imem_addr, 32'h104);
    check("seq_depc0", de_pc, 32'h100);
    check("seq_instr0", de_instr, 32'hBFEF_0100);

    // Three wait cycles at 0x104 produce bubbles with the address held.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("wait_addr", imem.imem_addr, 32'h104);
      check("wait_bubble", 32'(de_valid), 32'h0);
    end
    step(0, 0, 0, 0, 1);
    check("wait_done_pc", de_pc, 32'h104);
    check("wait_done_instr", de_instr, 32'hBFEB_0104);
    check("wait_next_addr", imem.imem_addr, 32'h108);

    // Stall as 0x108 arrives: word is parked, request dropped, IF/DE frozen.
    step(1, 0, 0, 0, 1);
    check("hold_req", 32'(imem.imem_req), 32'h0);
    check("hold_depc", de_pc, 32'h104);
    step(1, 0, 0, 0, 1);
    check("hold_req2", 32'(imem.imem_req), 32'h0);
    step(0, 0, 0, 0, 0);
    check("hold_rel_pc", de_pc, 32'h108);
    check("hold_rel_instr", de_instr, 32'hBFE7_0108);
    check("hold_rel_addr", imem.imem_addr, 32'h10C);

    // Redirect while 0x10C is outstanding: drain it, then fetch 0x200.
    step(0, 0, 1, 32'h200, 0);
    check("drain_addr", imem.imem_addr, 32'h10C);
    step(0, 0, 0, 0, 0);
    check("drain_addr2", imem.imem_addr, 32'h10C);
    step(0, 0, 0, 0, 1);
    check("drain_discard", 32'(de_valid), 32'h0);
    check("redir_addr", imem.imem_addr, 32'h200);
    step(0, 0, 0, 0, 1);
    check("redir_depc", de_pc, 32'h200);

    // Clear beats stall; PC does not move.
    step(1, 1, 0, 0, 0);
    check("clr_valid", 32'(de_valid), 32'h0);
    check("clr_instr", de_instr, 32'h0);
    check("clr_addr", imem.imem_addr, 32'h204);

    // PC wrap and target alignment.
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    check("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    check("wrap_depc", de_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", de_pc_plus4, 32'h0);
    check("wrap_next", imem.imem_addr, 32'h0);
    step(0, 0, 1, 32'h203, 1);
    check("align_addr", imem.imem_addr, 32'h200);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 4) < 3);

    // Asynchronous reset in the middle of activity.
    @(posedge clk);
    #2 rst_in = 1'b1;
    model_reset();
    #1;
    check("arst_req", 32'(imem.imem_req), 32'h0);
    check("arst_valid", 32'(de_valid), 32'h0);
    @(posedge clk);
    #2 rst_in = 1'b0;
    @(negedge clk);
    check("arst_addr", imem.imem_addr, 32'h100);

    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 1) == 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
